room_thermal_model: RTL
=======================

// Module: room_thermal_model
// PURPOSE
//  Behavioural plant model closing the loop around the AC controller: consumes heating/cooling
//  commands and produces the 5-bit room temperature (deg C) fed back to the controller.
//  Temperature steps by 1 every N clocks:
//  - up when heating;
//  - down when cooling;
//  - toward ambient when both are off.
//  Used in closed-loop benches and on-board demos.
// PARAMETERS
//  T_INIT     20  temperature loaded on reset (0..31)
//  T_AMBIENT  12  value drifted toward when idle (0..31)
//  HEAT_DIV    4  clocks per +1 step while heating (1..255)
//  COOL_DIV    4  clocks per -1 step while cooling (1..255)
//  DRIFT_DIV   8  clocks per 1-step move toward T_AMBIENT while idle (1..255)
// PORTS
//  clk          in   1  system clock, all state on rising edge
//  rst          in   1  synchronous, active-high reset
//  heating      in   1  heater command from controller
//  cooling      in   1  cooler command from controller
//  temperature  out  5  current room temperature, unsigned deg C, registered
//  step         out  1  one-cycle pulse in the cycle temperature has just changed
//  fault        out  1  high while state==FAULT (heating and cooling both asserted)
// BEHAVIOUR
//  - Reset (rst=1 at posedge):
//    - temperature=T_INIT, state=DRIFT, cnt=0, step=0, fault=0.
//    - Reset mid-operation aborts any partial count.
//  - States: DRIFT (h=0,c=0), HEAT (h=1,c=0), COOL (h=0,c=1), FAULT (h=1,c=1).
//    - Decoded from inputs every cycle.
//  - Each posedge, priority order:
//    1. decoded != state: state<=decoded; cnt<=0; no step. Mode change costs one cycle.
//    2. else if state!=FAULT and cnt==DIV(state)-1: cnt<=0; apply step; step<=1.
//    3. else: cnt<=cnt+1 (held at 0 in FAULT); step<=0.
//  - Latency, HEAT_DIV=4, heating rises at edge k:
//    - state=HEAT after edge k.
//    - First +1 visible after edge k+4, then every 4 edges.
//  - DIV=1: a step every cycle once the state is stable.
//  - Step rules:
//    - HEAT: +1, saturates at 31.
//    - COOL: -1, saturates at 0.
//    - DRIFT: +1 if below T_AMBIENT, -1 if above, none if equal.
//    - A saturated or no-change step still reloads cnt; step pulses only if the value changed.
//  - FAULT: temperature frozen; fault=1 from the edge after both commands are seen.
//    - Leaving FAULT follows rule 1.
//  - Widths: cnt 8 bits unsigned.
//    - Temperature arithmetic in 6 bits, then clamped to 0..31. Never wraps.
// CONFIGURATION
//  - Macro ROOM_NOISE_EN defined: 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1.
//    - Seed 8'hA5 on rst; advances every cycle.
//    - A due step is suppressed when lfsr[2:0]==3'b000: cnt still reloads, step stays 0.
//  - ROOM_NOISE_EN undefined: no LFSR logic; every due step is applied (fully deterministic).
// STRUCTURE
//  - Shared package room_model_pkg:
//    - TEMP_W=5, TEMP_MIN=0, TEMP_MAX=31.
//    - typedef enum logic[1:0] room_mode_t {DRIFT,HEAT,COOL,FAULT}.
//    - LFSR_SEED=8'hA5.
//  - One sub-module: room_noise_lfsr (clk, rst, lfsr[7:0]), instantiated only under ROOM_NOISE_EN.
//  - Prescaler and state logic stay in the top module.
// TESTING (defaults, ROOM_NOISE_EN undefined unless stated)
//  1. Reset: rst=1 for 2 cycles, then 0 with h=c=0 -> temperature=20, step=0, fault=0 after reset.
//     Then 19 after 8 stable cycles.
//  2. Heat ramp: heating=1 from reset release.
//     -> 21 on 5th edge, 22 on 9th, +1 every 4 edges.
//     -> saturates at 31, step=0 thereafter.
//  3. Cool ramp: force cooling=1 from 5.
//     -> 1-step decrements every 4 edges down to 0; holds 0, no wrap to 31.
//  4. Drift: idle from 20.
//     -> reaches 12 after 1+8*8 edges, then stays 12 with no step pulses.
//  5. Fault: heating=cooling=1 at temperature 25 for 20 cycles.
//     -> fault=1 next edge, temperature stays 25.
//     -> release to heating only: fault=0, 26 four edges after state change.
//  6. Reset mid-count: heating at cnt=2, rst for 1 cycle.
//     -> temperature=20, cnt=0, next +1 only after a full 1+4-edge sequence.
//     Rerun with ROOM_NOISE_EN: LFSR sequence matches a golden model.
//     -> suppressed steps occur exactly where lfsr[2:0]==0.

Source files
------------

// File: rtl/room_model_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : room_model_pkg
//  Purpose  : Shared types and constants for the room thermal plant model.
//             Holds the temperature range, the operating-mode encoding and
//             the noise LFSR seed.
//  Ports    : none (package)
//  Config   : ROOM_NOISE_EN (consumed by room_thermal_model)
//  Revision : 1.0 - initial release
// ============================================================================
package room_model_pkg;

    localparam int          TEMP_W    = 5;
    localparam logic [4:0]  TEMP_MIN  = 5'd0;
    localparam logic [4:0]  TEMP_MAX  = 5'd31;
    localparam logic [7:0]  LFSR_SEED = 8'hA5;

    // Encoding chosen so that {cooling, heating} maps directly onto a mode.
    typedef enum logic [1:0] {
        DRIFT = 2'd0,
        HEAT  = 2'd1,
        COOL  = 2'd2,
        FAULT = 2'd3
    } room_mode_t;

endpackage
`default_nettype wire

// File: rtl/room_noise_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : room_noise_lfsr
//  Purpose  : 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used to randomly
//             suppress temperature steps. Advances every clock, reloads the
//             seed on reset.
//  Ports    : clk  - system clock
//             rst  - synchronous active-high reset (loads LFSR_SEED)
//             lfsr - current register contents
//  Config   : instantiated only when ROOM_NOISE_EN is defined
//  Revision : 1.0 - initial release
// ============================================================================
module room_noise_lfsr
    import room_model_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] lfsr
);

    logic [7:0] r_lfsr;
    logic       w_feedback;

    // Taps at polynomial degrees 8,6,5,4 -> register bits 7,5,4,3.
    assign w_feedback = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_feedback};
        end
    end

    assign lfsr = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/room_thermal_model.sv
`default_nettype none
// ============================================================================
//  Module   : room_thermal_model
//  Purpose  : Behavioural room plant. Temperature moves one degree every
//             HEAT_DIV / COOL_DIV / DRIFT_DIV clocks: up when heating, down
//             when cooling, toward T_AMBIENT when idle, frozen when both
//             commands are asserted (fault).
//  Ports    : clk         - system clock, rising edge
//             rst         - synchronous active-high reset
//             heating     - heater command
//             cooling     - cooler command
//             temperature - registered room temperature (0..31 deg C)
//             step        - one-cycle pulse when temperature just changed
//             fault       - high while both commands are held
//  Config   : ROOM_NOISE_EN - when defined, an LFSR randomly suppresses
//             due steps (lfsr[2:0]==0); otherwise fully deterministic.
//  Revision : 1.0 - initial release
// ============================================================================
module room_thermal_model
    import room_model_pkg::*;
#(
    parameter int T_INIT    = 20,
    parameter int T_AMBIENT = 12,
    parameter int HEAT_DIV  = 4,
    parameter int COOL_DIV  = 4,
    parameter int DRIFT_DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       heating,
    input  logic       cooling,
    output logic [4:0] temperature,
    output logic       step,
    output logic       fault
);

    localparam logic [4:0] C_T_INIT     = 5'(T_INIT);
    localparam logic [4:0] C_T_AMBIENT  = 5'(T_AMBIENT);
    localparam logic [7:0] C_HEAT_LAST  = 8'(HEAT_DIV - 1);
    localparam logic [7:0] C_COOL_LAST  = 8'(COOL_DIV - 1);
    localparam logic [7:0] C_DRIFT_LAST = 8'(DRIFT_DIV - 1);

    localparam logic [5:0] C_PLUS_ONE  = 6'h01;
    localparam logic [5:0] C_MINUS_ONE = 6'h3F;

    room_mode_t r_state;
    logic [7:0] r_cnt;
    logic [4:0] r_temp;
    logic       r_step;

    room_mode_t w_decoded;
    logic [7:0] w_last;
    logic [5:0] w_delta;
    logic [5:0] w_sum;
    logic [4:0] w_target;
    logic       w_due;
    logic       w_apply;
    logic       w_suppress;

`ifdef ROOM_NOISE_EN
    logic [7:0] w_lfsr;

    room_noise_lfsr u_noise (
        .clk  (clk),
        .rst  (rst),
        .lfsr (w_lfsr)
    );

    assign w_suppress = (w_lfsr[2:0] == 3'b000);
`else
    assign w_suppress = 1'b0;
`endif

    // Decode the commands and work out the candidate next temperature.
    always_comb begin
        w_decoded = room_mode_t'({cooling, heating});
        w_last    = 8'd0;
        w_delta   = 6'd0;
        case (r_state)
            HEAT: begin
                w_last  = C_HEAT_LAST;
                w_delta = C_PLUS_ONE;
            end
            COOL: begin
                w_last  = C_COOL_LAST;
                w_delta = C_MINUS_ONE;
            end
            DRIFT: begin
                w_last = C_DRIFT_LAST;
                if (r_temp < C_T_AMBIENT) begin
                    w_delta = C_PLUS_ONE;
                end else if (r_temp > C_T_AMBIENT) begin
                    w_delta = C_MINUS_ONE;
                end
            end
            default: begin
                w_last  = 8'd0;
                w_delta = 6'd0;
            end
        endcase

        // 6-bit sum: 31+1 lands on 32 and 0-1 lands on 63, both above the
        // legal range, so the direction of travel picks the clamp value.
        w_sum = {1'b0, r_temp} + w_delta;
        if (w_sum > {1'b0, TEMP_MAX}) begin
            w_target = (w_delta == C_PLUS_ONE) ? TEMP_MAX : TEMP_MIN;
        end else begin
            w_target = w_sum[4:0];
        end

        w_due   = (r_state != FAULT) && (r_cnt == w_last);
        w_apply = w_due && !w_suppress && (w_target != r_temp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DRIFT;
            r_cnt   <= 8'd0;
            r_temp  <= C_T_INIT;
            r_step  <= 1'b0;
        end else if (w_decoded != r_state) begin
            // A mode change spends its cycle restarting the prescaler.
            r_state <= w_decoded;
            r_cnt   <= 8'd0;
            r_step  <= 1'b0;
        end else if (w_due) begin
            // Prescaler reloads even when the step is clamped or suppressed.
            r_cnt  <= 8'd0;
            r_step <= w_apply;
            if (w_apply) begin
                r_temp <= w_target;
            end
        end else begin
            r_cnt  <= (r_state == FAULT) ? 8'd0 : r_cnt + 8'd1;
            r_step <= 1'b0;
        end
    end

    assign temperature = r_temp;
    assign step        = r_step;
    assign fault       = (r_state == FAULT);

endmodule
`default_nettype wire
